// File: rtl/uch_pkg.sv
// uch_pkg: shared constants, count type and default terminal-count helper for the uch counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   UCH_DEFAULT_WIDTH - default count width (hexadecimal digit)
//   UCH_MAX_WIDTH     - widest WIDTH the int-based parameter arithmetic supports
//   uch_cnt_t         - count value at the default width
//   uch_default_max() - terminal count for a given width (all ones)
package uch_pkg;

    localparam int UCH_DEFAULT_WIDTH = 4;

    // MAX_VAL is carried as a signed int, so 2**WIDTH must stay representable.
    localparam int UCH_MAX_WIDTH = 30;

    typedef logic [UCH_DEFAULT_WIDTH-1:0] uch_cnt_t;

    // Natural modulo-2**width counting: the terminal value is all ones.
    function automatic int uch_default_max(input int width);
        return (2 ** width) - 1;
    endfunction

endpackage

// File: rtl/uch_next.sv
// uch_next: combinational next-count and wrap detector for the uch counter.
// Latency: zero (pure combinational, no state).
// Backpressure: none; when en is low the current value is passed through unchanged.
//
// Ports:
//   cur  [WIDTH] - current registered count
//   en   [1]     - count enable
//   nxt  [WIDTH] - value the count register should load on the next edge
//   wrap [1]     - high when this edge takes the count from MAX_VAL back to 0
module uch_next
    import uch_pkg::*;
#(
    parameter int WIDTH   = UCH_DEFAULT_WIDTH,
    parameter int MAX_VAL = uch_default_max(WIDTH)
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             en,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    always_comb begin
        wrap = en && (cur == MAX_C);
        nxt  = cur;
        if (wrap) begin
            // Explicit compare-and-clear rather than relying on overflow, so a
            // terminal value below all-ones (e.g. decimal 9) wraps on the same edge.
            nxt = '0;
        end else if (en) begin
            nxt = cur + 1'b1;
        end
    end

endmodule

// File: rtl/uch.sv
// uch: enable-gated synchronous up counter, wraps MAX_VAL -> 0 with no dead cycle.
// Latency: one uch_clk edge from an enabled edge to the new uch_out value.
// Backpressure: none; output is always valid, uch_en=0 holds the count indefinitely.
//
// Ports:
//   uch_clk        - rising-edge clock
//   uch_rst        - synchronous active-high reset, has priority over uch_en
//   uch_en         - count enable
//   uch_out[WIDTH] - current count, taken straight from a register
//   uch_tc         - (only when UCH_TC_EN is defined) one-cycle pulse after each
//                    MAX_VAL -> 0 wrap
//
// Build option: define UCH_TC_EN to add the registered terminal-count pulse uch_tc.
module uch
    import uch_pkg::*;
#(
    parameter int WIDTH   = UCH_DEFAULT_WIDTH,
    parameter int MAX_VAL = uch_default_max(WIDTH)
) (
    input  logic             uch_clk,
    input  logic             uch_rst,
    input  logic             uch_en,
`ifdef UCH_TC_EN
    output logic             uch_tc,
`endif
    output logic [WIDTH-1:0] uch_out
);

    // ------------------------------------------------------------------
    // Configuration checks: reject illegal widths / terminal counts at
    // elaboration instead of silently truncating MAX_VAL.
    // ------------------------------------------------------------------
    generate
        if ((WIDTH < 1) || (WIDTH > UCH_MAX_WIDTH)) begin : g_bad_width
            $error("uch: WIDTH=%0d outside supported range 1..%0d", WIDTH, UCH_MAX_WIDTH);
        end
        if ((MAX_VAL < 1) || (MAX_VAL > ((2 ** WIDTH) - 1))) begin : g_bad_max
            $error("uch: MAX_VAL=%0d outside legal range 1..%0d", MAX_VAL, (2 ** WIDTH) - 1);
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    // ------------------------------------------------------------------
    // Count register. The declaration initialiser gives the 0 power-up
    // value seen before the first reset edge.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] cnt_q = '0;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap;

    uch_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .cur  (cnt_q),
        .en   (uch_en),
        .nxt  (cnt_d),
        .wrap (wrap)
    );

    always_ff @(posedge uch_clk) begin
        if (uch_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign uch_out = cnt_q;

    // ------------------------------------------------------------------
    // Terminal-count pulse. wrap is only true on an enabled MAX_VAL edge,
    // so registering it yields exactly one high cycle after the wrap;
    // reset clears it even if that edge would otherwise have wrapped.
    // ------------------------------------------------------------------
`ifdef UCH_TC_EN
    logic tc_q = 1'b0;
    logic tc_d;

    assign tc_d = wrap;

    always_ff @(posedge uch_clk) begin
        if (uch_rst) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= tc_d;
        end
    end

    assign uch_tc = tc_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap;
`endif

    // The count can never leave 0..MAX_VAL.
    a_cnt_in_range: assert property (@(posedge uch_clk) cnt_q <= MAX_C);

endmodule

// File: tb/tb_uch.sv
module tb_uch;
    import uch_pkg::*;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    // DUT A: default hex counter (MAX_VAL=15). DUT B: decimal variant (MAX_VAL=9).
    logic     rst_a = 1'b0;
    logic     en_a  = 1'b0;
    logic     rst_b = 1'b1;
    logic     en_b  = 1'b0;
    uch_cnt_t out_a;
    uch_cnt_t out_b;
`ifdef UCH_TC_EN
    logic     tc_a;
    logic     tc_b;
`endif

    uch #(.WIDTH(4)) u_dut_a (
        .uch_clk (clk),
        .uch_rst (rst_a),
        .uch_en  (en_a),
`ifdef UCH_TC_EN
        .uch_tc  (tc_a),
`endif
        .uch_out (out_a)
    );

    uch #(.WIDTH(4), .MAX_VAL(9)) u_dut_b (
        .uch_clk (clk),
        .uch_rst (rst_b),
        .uch_en  (en_b),
`ifdef UCH_TC_EN
        .uch_tc  (tc_b),
`endif
        .uch_out (out_b)
    );

    typedef struct {
        bit       sel;      // 0 = DUT A, 1 = DUT B
        uch_cnt_t exp_out;
        logic     exp_tc;
        string    tag;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        vectors     = 0;
    int        miscompares = 0;

    // ------------------------------------------------------------------
    // Monitor: on every falling edge, check every expectation queued since
    // the previous one against the selected DUT.
    // ------------------------------------------------------------------
    sb_entry_t mon_e;
    uch_cnt_t  mon_out;
    logic      mon_tc;

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_out = mon_e.sel ? out_b : out_a;
            vectors++;
            if (mon_out !== mon_e.exp_out) begin
                miscompares++;
                $display("FAIL %s (dut %0d): uch_out=%0d expected %0d",
                         mon_e.tag, mon_e.sel, mon_out, mon_e.exp_out);
            end
`ifdef UCH_TC_EN
            mon_tc = mon_e.sel ? tc_b : tc_a;
            vectors++;
            if (mon_tc !== mon_e.exp_tc) begin
                miscompares++;
                $display("FAIL %s_tc (dut %0d): uch_tc=%0b expected %0b",
                         mon_e.tag, mon_e.sel, mon_tc, mon_e.exp_tc);
            end
`else
            mon_tc = mon_e.exp_tc;
`endif
        end
    end

    task automatic push_exp(input bit sel, input int exp_o, input logic exp_tc, input string tag);
        sb_entry_t e;
        e.sel     = sel;
        e.exp_out = 4'(exp_o);
        e.exp_tc  = exp_tc;
        e.tag     = tag;
        sb_q.push_back(e);
    endtask

    // Apply inputs for one edge, then queue the value expected after that edge.
    task automatic step(input bit sel, input logic rst, input logic en,
                        input int exp_o, input logic exp_tc, input string tag);
        if (sel) begin
            rst_b = rst;
            en_b  = en;
        end else begin
            rst_a = rst;
            en_a  = en;
        end
        @(posedge clk);
        push_exp(sel, exp_o, exp_tc, tag);
        #1;
    endtask

    int dec_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    initial begin
        // Power-up value, observed at t=5 before the first rising edge.
        push_exp(1'b0, 0, 1'b0, "powerup");
        push_exp(1'b1, 0, 1'b0, "powerup");

        // Reset held with enable high: count stays at 0.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 0, 1'b0, "rst_en");

        // Free count: 1..15, 0, 1..4; tc only after the 15 -> 0 edge.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, (i + 1) % 16, (i == 15), "free");

        // Count on to 7, hold for 20 cycles, then re-enable to 8.
        step(1'b0, 1'b0, 1'b1, 5, 1'b0, "to7");
        step(1'b0, 1'b0, 1'b1, 6, 1'b0, "to7");
        step(1'b0, 1'b0, 1'b1, 7, 1'b0, "to7");
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 7, 1'b0, "hold");
        step(1'b0, 1'b0, 1'b1, 8, 1'b0, "reenable");

        // Reset pulse at 11 with enable high, then resume from 0.
        step(1'b0, 1'b0, 1'b1, 9,  1'b0, "to11");
        step(1'b0, 1'b0, 1'b1, 10, 1'b0, "to11");
        step(1'b0, 1'b0, 1'b1, 11, 1'b0, "to11");
        step(1'b0, 1'b1, 1'b1, 0,  1'b0, "midrst");
        step(1'b0, 1'b0, 1'b1, 1,  1'b0, "resume");

        // Hold at the terminal value, wrap on a single enabled edge, then hold at 0.
        for (int v = 2; v <= 15; v++) step(1'b0, 1'b0, 1'b1, v, 1'b0, "to15");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 15, 1'b0, "hold15");
        step(1'b0, 1'b0, 1'b1, 0, 1'b1, "wrap");
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, "hold0");

        // Reset at the terminal value with enable high: no wrap pulse.
        for (int v = 1; v <= 15; v++) step(1'b0, 1'b0, 1'b1, v, 1'b0, "to15b");
        step(1'b0, 1'b1, 1'b1, 0, 1'b0, "rst_at15");
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, "after_rst15");

        // Decimal variant from reset: 1..9, 0, 1, 2 with tc after 9 -> 0.
        step(1'b1, 1'b1, 1'b1, 0, 1'b0, "dec_rst");
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, dec_exp[i], (i == 9), "dec");

        // Let the monitor drain, then confirm nothing was left unchecked.
        @(negedge clk);
        #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        miscompares++;
        $display("FAIL watchdog: time limit reached, stimulus did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uch.md
Name: uch

Overview:
- `uch` is an enable-gated synchronous up counter with a hexadecimal 4-bit default output.
- It advances by one on every rising clock edge while enabled, and wraps from its terminal value back to zero.
- It is a leaf block that feeds display drivers and downstream sequencers.

Parameters:
- WIDTH, 4, bit width of the count output.
- MAX_VAL, 2**WIDTH-1 (15), terminal count value.
  - After MAX_VAL the counter wraps to 0.
  - Legal range is 1..2**WIDTH-1.
  - Any value outside this range is a configuration error, flagged by an elaboration-time check.

Ports:
- uch_clk  input  1  rising-edge clock.
- uch_rst  input  1  synchronous, active-high reset.
- uch_en  input  1  count enable, active-high.
- uch_out  output  WIDTH  current count, driven directly from a register.

Behaviour:
- All state updates occur on the rising edge of uch_clk only. The block has no asynchronous paths.
- Reset:
  - If uch_rst=1 at the edge, uch_out becomes 0 at that edge.
  - Reset has priority over uch_en; counting is blocked for as long as reset is held.
  - Before the first reset edge, uch_out is 0 in simulation (power-up initial value 0).
- Count:
  - If uch_rst=0 and uch_en=1, uch_out <= (uch_out==MAX_VAL) ? 0 : uch_out+1.
  - Latency is one edge: the new value is visible immediately after the edge.
- Hold: if uch_rst=0 and uch_en=0, uch_out keeps its value indefinitely.
- Wrap-around:
  - MAX_VAL -> 0 occurs on one enabled edge, with no dead cycle.
  - When MAX_VAL=2**WIDTH-1, this matches natural modulo-2**WIDTH overflow.
- Reset mid-count: uch_out goes to 0 on the next edge regardless of enable. Counting resumes from 0 on the first edge after reset deasserts with en=1.
- Input changes between edges have no effect until the next edge.
- Outputs are glitch-free, with no combinational path from inputs to uch_out.

Optional Feature:
- Macro: UCH_TC_EN.
- When defined, the block adds output port uch_tc (1 bit).
  - uch_tc is a registered pulse, high for exactly one cycle following the edge on which uch_out wrapped MAX_VAL -> 0 under enable.
  - uch_tc resets to 0.
  - uch_tc is forced to 0 on any reset edge.
- When not defined, uch_tc does not exist and port list and behaviour are exactly as above.

Decomposition:
- Package uch_pkg holds:
  - UCH_DEFAULT_WIDTH = 4.
  - A function for the default MAX_VAL given a width.
  - The count typedef logic [UCH_DEFAULT_WIDTH-1:0] uch_cnt_t.
- Sub-module uch_next is a purely combinational next-value/wrap computer.
  - Inputs: cur, en. Outputs: nxt, wrap.
  - uch instantiates it and owns all registers.

Test Plan:
- Clock period is 10 ns.
- Reset with enable:
  - Stimulus: uch_rst=1, uch_en=1 for 20 cycles.
  - Required response: uch_out==0 throughout, so reset dominates enable.
- Free count:
  - Stimulus: after reset, uch_rst=0, uch_en=1 for 20 cycles.
  - Required response: uch_out sequence 1,2,...,15,0,1,2,3,4.
  - With UCH_TC_EN, uch_tc=1 only in the cycle after 15->0.
- Hold:
  - Stimulus: count to 7, then uch_en=0 for 20 cycles.
  - Required response: uch_out stays 7. Re-enabling yields 8 on the next edge.
- Reset mid-count:
  - Stimulus: at uch_out=11, pulse uch_rst=1 for one edge with uch_en=1.
  - Required response: uch_out=0 after that edge, then 1 on the following enabled edge.
- Decimal variant:
  - Stimulus: MAX_VAL=9, uch_en=1 for 12 cycles from reset.
  - Required response: 1..9,0,1,2.
  - With UCH_TC_EN, the uch_tc pulse follows 9->0.
